// File: rtl/op_issue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | op_issue_pkg : select encodings and command entry type              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package op_issue_pkg;

   localparam logic [1:0] SEL_INC  = 2'b00;
   localparam logic [1:0] SEL_PASS = 2'b01;
   localparam logic [1:0] SEL_DEC  = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

   localparam int CMD_W = 10;

   typedef struct packed {
      logic [7:0] number;
      logic [1:0] op;
   } cmd_t;

endpackage
`default_nettype wire

// File: rtl/op_issue_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | op_issue_mem : DEPTH x cmd_t storage, sync write, async head read   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module op_issue_mem
   import op_issue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  cmd_t          wr_data,
   input  logic [AW-1:0] rd_addr,
   output cmd_t          rd_data
);

   // No reset: occupancy is tracked by the pointers, contents are don't-care
   cmd_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/op_issue_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | op_issue_fifo : command queue feeding a registered op/operand pair  |
// | Optional statistics counters: define OP_ISSUE_STATS_EN              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module op_issue_fifo
   import op_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_number,
   input  logic [1:0]               in_op,
   input  logic                     flush,
   input  logic                     out_en,
   output logic [7:0]               out_number,
   output logic [1:0]               out_select,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              issued_cnt,
   output logic [15:0]              starve_cnt
);

   localparam int             AW       = $clog2(DEPTH);
   localparam int             CW       = AW + 1;
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_out_number;
   logic [1:0]    r_out_select;
   logic          w_accept;
   logic          w_issue;
   cmd_t          w_wr_cmd;
   cmd_t          w_head;

   assign in_ready = (r_count < FULL_CNT) && !flush && !RST;
   assign w_accept = in_valid && in_ready;
   assign w_issue  = out_en && (r_count != '0) && !flush && !RST;
   assign w_wr_cmd = '{number: in_number, op: in_op};

   op_issue_mem #(
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_accept),
      .wr_addr (r_wr_ptr),
      .wr_data (w_wr_cmd),
      .rd_addr (r_rd_ptr),
      .rd_data (w_head)
   );

   always_ff @(posedge clk) begin
      if (RST || flush) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_out_number <= 8'h00;
         r_out_select <= SEL_HOLD;
      end else begin
         if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_issue)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_accept, w_issue})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // Idle cycles present a hold op so the downstream result is kept
         if (w_issue) begin
            r_out_number <= w_head.number;
            r_out_select <= w_head.op;
         end else begin
            r_out_number <= 8'h00;
            r_out_select <= SEL_HOLD;
         end
      end
   end

   assign out_number = r_out_number;
   assign out_select = r_out_select;
   assign count      = r_count;

`ifdef OP_ISSUE_STATS_EN
   logic [15:0] r_issued_cnt;
   logic [15:0] r_starve_cnt;

   // Statistics survive flush; only RST clears them
   always_ff @(posedge clk) begin
      if (RST) begin
         r_issued_cnt <= '0;
         r_starve_cnt <= '0;
      end else begin
         if (w_issue && (r_issued_cnt != 16'hFFFF))
            r_issued_cnt <= r_issued_cnt + 16'd1;
         if (out_en && (r_count == '0) && (r_starve_cnt != 16'hFFFF))
            r_starve_cnt <= r_starve_cnt + 16'd1;
      end
   end

   assign issued_cnt = r_issued_cnt;
   assign starve_cnt = r_starve_cnt;
`else
   assign issued_cnt = 16'h0000;
   assign starve_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_op_issue_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_op_issue_fifo : directed self-checking bench for op_issue_fifo   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_op_issue_fifo;

   logic        clk = 1'b0;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_number;
   logic [1:0]  in_op;
   logic        flush;
   logic        out_en;
   logic [7:0]  out_number;
   logic [1:0]  out_select;
   logic [2:0]  count;
   logic [15:0] issued_cnt;
   logic [15:0] starve_cnt;

   int total  = 0;
   int passed = 0;

   op_issue_fifo #(.DEPTH(4)) dut (
      .clk        (clk),
      .RST        (RST),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_number  (in_number),
      .in_op      (in_op),
      .flush      (flush),
      .out_en     (out_en),
      .out_number (out_number),
      .out_select (out_select),
      .count      (count),
      .issued_cnt (issued_cnt),
      .starve_cnt (starve_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_idle(input logic [7:0] n, input logic [1:0] op);
      in_valid  = 1'b1;
      in_number = n;
      in_op     = op;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; in_valid = 1'b0; in_number = 8'h00; in_op = 2'b00;
      flush = 1'b0; out_en = 1'b0;
      step(); step();
      total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
      total++; if ({out_select, out_number} !== {2'b11, 8'h00})
         $display("FAIL reset_outputs: got %b/%h expected 11/00", out_select, out_number); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
      RST = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else passed++;
   endtask

   task automatic test_single_issue();
      out_en = 1'b1;
      push_idle(8'h10, 2'b00);
      total++; if ({count, out_select} !== {3'd1, 2'b11})
         $display("FAIL single_accept: got count=%0d sel=%b expected count=1 sel=11", count, out_select); else passed++;
      step();
      total++; if ({out_select, out_number} !== {2'b00, 8'h10})
         $display("FAIL single_issue: got %b/%h expected 00/10", out_select, out_number); else passed++;
      total++; if (count !== 3'd0) $display("FAIL single_count: got %0d expected 0", count); else passed++;
      step();
      total++; if ({out_select, out_number} !== {2'b11, 8'h00})
         $display("FAIL single_idle: got %b/%h expected 11/00", out_select, out_number); else passed++;
      out_en = 1'b0;
   endtask

   task automatic test_full();
      logic [7:0] exp_n [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      logic [1:0] exp_o [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      out_en = 1'b0;
      for (int i = 0; i < 4; i++) push_idle(exp_n[i], exp_o[i]);
      total++; if ({count, in_ready} !== {3'd4, 1'b0})
         $display("FAIL full_state: got count=%0d rdy=%b expected count=4 rdy=0", count, in_ready); else passed++;
      push_idle(8'hB5, 2'b01);
      total++; if (count !== 3'd4) $display("FAIL full_reject: got %0d expected 4", count); else passed++;
      total++; if (out_select !== 2'b11) $display("FAIL full_hold_head: got sel=%b expected 11", out_select); else passed++;
      out_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if ({out_number, out_select, count} !== {exp_n[i], exp_o[i], 3'(3 - i)})
            $display("FAIL full_drain_%0d: got %h/%b cnt=%0d expected %h/%b cnt=%0d",
                     i, out_number, out_select, count, exp_n[i], exp_o[i], 3 - i); else passed++;
      end
      out_en = 1'b0;
      step();
      total++; if (out_select !== 2'b11) $display("FAIL full_after_drain: got sel=%b expected 11", out_select); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] en;
      logic [1:0] eo;
      out_en = 1'b0;
      push_idle(8'h31, 2'b01);
      push_idle(8'h32, 2'b10);
      in_valid = 1'b1;
      out_en   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_number = 8'h20 + 8'(i);
         in_op     = 2'(i);
         step();
         if (i == 0)      begin en = 8'h31; eo = 2'b01; end
         else if (i == 1) begin en = 8'h32; eo = 2'b10; end
         else             begin en = 8'h20 + 8'(i - 2); eo = 2'(i - 2); end
         total++; if ({out_number, out_select, count} !== {en, eo, 3'd2})
            $display("FAIL b2b_%0d: got %h/%b cnt=%0d expected %h/%b cnt=2",
                     i, out_number, out_select, count, en, eo); else passed++;
      end
      in_valid = 1'b0;
      step();
      total++; if ({out_number, out_select} !== {8'h28, 2'b00})
         $display("FAIL b2b_tail0: got %h/%b expected 28/00", out_number, out_select); else passed++;
      step();
      total++; if ({out_number, out_select, count} !== {8'h29, 2'b01, 3'd0})
         $display("FAIL b2b_tail1: got %h/%b cnt=%0d expected 29/01 cnt=0", out_number, out_select, count); else passed++;
      out_en = 1'b0;
      step();
   endtask

   task automatic test_flush();
      out_en = 1'b0;
      push_idle(8'h51, 2'b00);
      push_idle(8'h52, 2'b01);
      push_idle(8'h53, 2'b10);
      total++; if (count !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", count); else passed++;
      flush = 1'b1; in_valid = 1'b1; in_number = 8'h5F; out_en = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready); else passed++;
      step();
      flush = 1'b0; in_valid = 1'b0;
      total++; if ({count, out_select, out_number} !== {3'd0, 2'b11, 8'h00})
         $display("FAIL flush_state: got cnt=%0d %b/%h expected cnt=0 11/00", count, out_select, out_number); else passed++;
      step();
      total++; if ({count, out_select, out_number} !== {3'd0, 2'b11, 8'h00})
         $display("FAIL flush_after: got cnt=%0d %b/%h expected cnt=0 11/00", count, out_select, out_number); else passed++;
      out_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_en = 1'b0;
      push_idle(8'h61, 2'b00);
      push_idle(8'h62, 2'b01);
      RST = 1'b1; out_en = 1'b1;
      step();
      total++; if ({count, out_select, out_number, in_ready} !== {3'd0, 2'b11, 8'h00, 1'b0})
         $display("FAIL rstmid_state: got cnt=%0d %b/%h rdy=%b expected cnt=0 11/00 rdy=0",
                  count, out_select, out_number, in_ready); else passed++;
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if ({count, out_select, out_number} !== {3'd0, 2'b11, 8'h00})
            $display("FAIL rstmid_leak_%0d: got cnt=%0d %b/%h expected cnt=0 11/00",
                     i, count, out_select, out_number); else passed++;
      end
      out_en = 1'b0;
   endtask

   task automatic test_stats();
`ifdef OP_ISSUE_STATS_EN
      RST = 1'b1; step(); RST = 1'b0;
      out_en = 1'b1;
      step(); step(); step();
      out_en = 1'b0;
      for (int i = 0; i < 4; i++) push_idle(8'(8'h70 + i), 2'b01);
      out_en = 1'b1;
      step(); step(); step(); step();
      out_en = 1'b0;
      push_idle(8'h7F, 2'b00);
      out_en = 1'b1;
      step();
      out_en = 1'b0;
      step();
      total++; if (issued_cnt !== 16'd5) $display("FAIL stats_issued: got %0d expected 5", issued_cnt); else passed++;
      total++; if (starve_cnt !== 16'd3) $display("FAIL stats_starve: got %0d expected 3", starve_cnt); else passed++;
      flush = 1'b1; step(); flush = 1'b0;
      total++; if (issued_cnt !== 16'd5) $display("FAIL stats_flush_keep: got %0d expected 5", issued_cnt); else passed++;
      push_idle(8'h01, 2'b00);
      push_idle(8'h02, 2'b00);
      force dut.r_issued_cnt = 16'hFFFE;
      #1;
      release dut.r_issued_cnt;
      out_en = 1'b1;
      step(); step();
      out_en = 1'b0;
      total++; if (issued_cnt !== 16'hFFFF) $display("FAIL stats_saturate: got %h expected ffff", issued_cnt); else passed++;
`else
      total++; if (issued_cnt !== 16'd0) $display("FAIL stats_issued_off: got %0d expected 0", issued_cnt); else passed++;
      total++; if (starve_cnt !== 16'd0) $display("FAIL stats_starve_off: got %0d expected 0", starve_cnt); else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_single_issue();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_stats();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/op_issue_fifo.md
OP_ISSUE_FIFO -- requirements
Module: op_issue_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command queue depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream command valid.
REQ-005 SHALL have port in_ready  output  1  queue can accept a command this cycle.
REQ-006 SHALL have port in_number  input  8  operand.
REQ-007 SHALL have port in_op  input  2  opcode: 00 inc, 01 pass, 10 dec, 11 hold.
REQ-008 SHALL have port flush  input  1  synchronous queue clear.
REQ-009 SHALL have port out_en  input  1  downstream arithmetic stage may take an operation this cycle.
REQ-010 SHALL have port out_number  output  8  registered operand to the arithmetic stage's number input.
REQ-011 SHALL have port out_select  output  2  registered select to the arithmetic stage's select input.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have ports issued_cnt, starve_cnt  output  16 each  statistics (see Configuration).

Function
REQ-014 A command SHALL be accepted on an edge where in_valid && in_ready; in_ready = (count < DEPTH) && !flush.
REQ-015 An issue SHALL occur on an edge where out_en && count != 0; the head entry loads into out_number/out_select and is popped.
REQ-016 On an edge with no issue, out_select SHALL load 2'b11 and out_number SHALL load 8'h00, so the downstream stage holds its result.
REQ-017 Latency: a command accepted into an empty queue at edge k SHALL appear on the outputs after edge k+1 at the earliest; no combinational input-to-output path.
REQ-018 Simultaneous accept and issue SHALL leave count unchanged; simultaneous accept and issue when full SHALL NOT happen, because in_ready is low when full.
REQ-019 Order SHALL be strictly FIFO; read and write pointers wrap modulo DEPTH.
REQ-020 Opcode 11 commands SHALL be queued and issued like the others, producing one hold cycle downstream.
REQ-021 flush SHALL empty the queue on that edge, override accept and issue, and load the outputs with 2'b11 / 8'h00.
REQ-022 out_en low SHALL never cause loss of a command; the queue head is retained.

Reset
REQ-023 While RST is high at an edge, the block SHALL apply: count 0, pointers 0, out_select 2'b11, out_number 8'h00, issued_cnt 0, starve_cnt 0.
REQ-024 While RST is high, in_ready SHALL be low.
REQ-025 Reset mid-operation SHALL discard all queued commands; nothing issues on that edge.

Configuration
REQ-026 Macro OP_ISSUE_STATS_EN SHALL gate the statistics logic.
REQ-027 With OP_ISSUE_STATS_EN defined:
  - issued_cnt SHALL increment on every issue.
  - starve_cnt SHALL increment on every edge with out_en high and count 0.
  - Both counters SHALL saturate at 16'hFFFF and clear on RST, not on flush.
REQ-028 Without OP_ISSUE_STATS_EN, issued_cnt and starve_cnt SHALL be constant 0 and no counter flops are inferred; the port list is unchanged.

Structure
REQ-029 Package op_issue_pkg SHALL hold:
  - SEL_INC=2'b00, SEL_PASS=2'b01, SEL_DEC=2'b10, SEL_HOLD=2'b11
  - the 10-bit command entry type {number, op}
REQ-030 Storage SHALL be one sub-module op_issue_mem:
  - DEPTH x 10-bit array
  - synchronous write, asynchronous read of the head
  - no reset on the array

Verification
REQ-031 Reset, then push {8'h10,00}, with out_en held high -> one edge later out_number=8'h10, out_select=00; the following edge out_select=11.
REQ-032 With out_en low, push 4 commands at DEPTH=4 -> count=4, in_ready=0; a 5th in_valid is not accepted; with out_en raised, the 4 commands issue in order over 4 edges.
REQ-033 With count=2, accept and issue on the same edge -> count stays 2, and order is preserved across pointer wrap after 10 such edges.
REQ-034 With 3 entries queued, assert flush with in_valid high -> count=0, nothing accepted, outputs become 11/00.
REQ-035 With 2 entries queued, assert RST for one edge -> all outputs at reset values; the old entries never appear downstream.
REQ-036 With OP_ISSUE_STATS_EN defined, 5 issues plus 3 starved edges -> issued_cnt=5, starve_cnt=3; with issued_cnt preloaded near FFFF by forcing, it saturates at 16'hFFFF; without the macro both read 0.
